// File: rtl/out_port_fifo.sv
// Output-port FIFO between the FP core and an external peripheral.
// Captures {addr, data} on every core strobe and drains them over valid/ready; writes into a full FIFO are dropped and counted.
module out_port_fifo #(
  parameter  int unsigned NBMANT = 16,
  parameter  int unsigned NBEXPO = 6,
  parameter  int unsigned NUIOOU = 8,
  parameter  int unsigned FDEPTH = 4,
  localparam int unsigned AW     = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int unsigned DW     = NBMANT + NBEXPO + 1,
  localparam int unsigned CW     = FDEPTH + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          out_en,
  input  logic [AW-1:0] addr_out,
  input  logic [DW-1:0] data_out,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] level,
  output logic          full,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned D = 2 ** FDEPTH;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t            r_mem [D];
  logic [FDEPTH-1:0] r_wp;
  logic [FDEPTH-1:0] r_rp;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic [7:0]        r_drop_cnt;

  logic   w_full;
  logic   w_pop;
  logic   w_blocked;
  logic   w_push;
  logic   w_drop;
  entry_t w_head;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    w_full    = (r_count == CW'(D));
    w_pop     = (r_count != '0) && m_ready;
    w_blocked = w_full && !w_pop;
    w_push    = out_en && !w_blocked;
    w_drop    = out_en && w_blocked;
    w_head    = r_mem[r_rp];
  end

  // Storage array is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= '{addr: addr_out, data: data_out};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + FDEPTH'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + FDEPTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Overflow bookkeeping: a drop in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (ovf_clr) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  always_comb begin
    m_valid  = (r_count != '0);
    m_addr   = w_head.addr;
    m_data   = w_head.data;
    level    = r_count;
    full     = w_full;
    ovf      = r_ovf;
    drop_cnt = r_drop_cnt;
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo: driver queues expected entries, a negedge monitor checks every handshake.
module tb_out_port_fifo;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 23;
  localparam int unsigned CW = 5;
  localparam int          D  = 16;

  logic          clk;
  logic          rst;
  logic          out_en;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [CW-1:0] level;
  logic          full;
  logic          ovf;
  logic          ovf_clr;
  logic [7:0]    drop_cnt;

  out_port_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .out_en   (out_en),
    .addr_out (addr_out),
    .data_out (data_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .level    (level),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_count = 0;
  int   m_ovf = 0;
  int   m_drop = 0;
  int   last_pop = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: act=0x%0h req=0x%0h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: the handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      n_cmp++;
      if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: act=0x%0h req=none @%0t", m_data, $time);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        if (m_addr != e.addr || m_data != e.data) begin
          n_err++;
          $display("FAIL pop_data: act=%0d/0x%0h req=%0d/0x%0h @%0t",
                   m_addr, m_data, e.addr, e.data, $time);
        end
        last_pop = int'(e.data);
      end
    end
  end

  // One clock cycle of stimulus plus a model update; entered and left at posedge+1.
  task automatic cyc(input logic en, input int a, input int d, input logic rdy, input logic clr);
    logic pop;
    logic blocked;
    out_en   = en;
    addr_out = AW'(a);
    data_out = DW'(d);
    m_ready  = rdy;
    ovf_clr  = clr;
    pop      = (m_count != 0) && rdy;
    blocked  = (m_count == D) && !pop;
    if (en && !blocked) begin
      q_exp.push_back('{addr: AW'(a), data: DW'(d)});
      if (!pop) m_count++;
    end else if (pop) begin
      m_count--;
    end
    if (en && blocked) begin
      m_ovf  = 1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    @(posedge clk);
    #1;
    chk("level", int'(level), m_count);
    chk("full", int'(full), int'(m_count == D));
    chk("m_valid", int'(m_valid), int'(m_count != 0));
    chk("ovf", int'(ovf), m_ovf);
    chk("drop_cnt", int'(drop_cnt), m_drop);
    out_en  = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 64;
    while (m_count != 0 && budget > 0) begin
      cyc(1'b0, 0, 0, 1'b1, 1'b0);
      budget--;
    end
    chk("drain_budget", int'(budget > 0), 1);
  endtask

  initial begin
    rst = 1'b1; out_en = 1'b0; addr_out = '0; data_out = '0; m_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mid-stream asynchronous reset with 3 entries held
    for (int i = 0; i < 3; i++) cyc(1'b1, i, 23'h55 + i, 1'b0, 1'b0);
    chk("pre_rst_level", int'(level), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(m_valid), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_drop", int'(drop_cnt), 0);
    q_exp.delete();
    m_count = 0; m_ovf = 0; m_drop = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 5, 23'h1ABCDE, 1'b0, 1'b0);
    chk("first_valid", int'(m_valid), 1);
    chk("first_addr", int'(m_addr), 5);
    chk("first_data", int'(m_data), 23'h1ABCDE);
    drain();

    // Ordering: ready asserted from cycle 3
    for (int i = 0; i < 10; i++) cyc(1'b1, i % 8, i, (i >= 3), 1'b0);
    drain();
    chk("order_last", last_pop, 9);
    chk("order_level", int'(level), 0);

    // Fill and overflow with sink stalled
    for (int i = 0; i < 18; i++) cyc(1'b1, i % 8, 100 + i, 1'b0, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_ovf", int'(ovf), 1);
    chk("fill_drop", int'(drop_cnt), 2);
    chk("fill_head_addr", int'(m_addr), 0);
    chk("fill_head_data", int'(m_data), 100);

    // Push while full with simultaneous pop
    cyc(1'b1, 7, 23'h3FF, 1'b1, 1'b0);
    chk("fullpop_level", int'(level), 16);
    chk("fullpop_drop", int'(drop_cnt), 2);
    drain();
    chk("fullpop_last", last_pop, 23'h3FF);

    // Pointer wrap with random ready
    for (int i = 0; i < 40; i++) cyc((i % 3) != 2, i % 8, 200 + i, 1'($urandom_range(0, 1)), 1'b0);
    chk("wrap_drop", int'(drop_cnt), 2);
    drain();

    // Drop counter saturation and clear priority
    for (int i = 0; i < 16; i++) cyc(1'b1, i % 8, 300 + i, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cyc(1'b1, 1, 23'h7FFFFF, 1'b0, 1'b0);
    chk("sat_drop", int'(drop_cnt), 255);
    cyc(1'b1, 2, 23'h7FFFFF, 1'b0, 1'b0);
    chk("sat_hold", int'(drop_cnt), 255);
    cyc(1'b0, 0, 0, 1'b0, 1'b1);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_drop", int'(drop_cnt), 0);
    cyc(1'b1, 3, 23'h7FFFFF, 1'b0, 1'b1);
    chk("clrset_ovf", int'(ovf), 1);
    chk("clrset_drop", int'(drop_cnt), 1);
    drain();
    chk("sat_last", last_pop, 315);

    @(negedge clk);
    chk("queue_empty", q_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
